// File: rtl/fp32_pkg.sv
// Shared binary32 constants and the sigmoid_backward FSM state type.
// The forward sigmoid and the backward block import the same definitions.
package fp32_pkg;

  localparam int unsigned SIGN_W   = 1;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned EXP_BIAS = 127;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    StIdle,
    StSub,
    StMul1,
    StMul2,
    StDone
  } state_e;

endpackage

// File: rtl/fp32_mul.sv
// Combinational binary32 multiplier: round-to-nearest-even, denormals flushed to signed zero,
// canonical quiet NaN for NaN operands and 0 * Inf, signed Inf on overflow.
//   a_i, b_i : binary32 operands
//   y_o      : binary32 product
module fp32_mul
  import fp32_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  logic              sign;
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]       prod;
  logic [23:0]       mant;
  logic              guard, sticky, round_up;
  logic [24:0]       mant_r;
  logic signed [9:0] exp_r;
  logic [22:0]       frac;

  assign sign   = a_i[31] ^ b_i[31];
  assign ea     = a_i[30:23];
  assign eb     = b_i[30:23];
  assign fa     = a_i[22:0];
  assign fb     = b_i[22:0];
  // Exponent zero covers both true zero and flushed denormals.
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (fa == '0);
  assign b_inf  = (eb == 8'hFF) && (fb == '0);
  assign a_nan  = (ea == 8'hFF) && (fa != '0);
  assign b_nan  = (eb == 8'hFF) && (fb != '0);

  always_comb begin
    prod  = {24'b0, 1'b1, fa} * {24'b0, 1'b1, fb};
    exp_r = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

    // Product of two 1.x mantissas lies in [1, 4); normalise by at most one bit.
    if (prod[47]) begin
      mant   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_r  = exp_r + 10'sd1;
    end else begin
      mant   = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end

    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {24'b0, round_up};
    if (mant_r[24]) begin
      exp_r = exp_r + 10'sd1;
      frac  = mant_r[23:1];
    end else begin
      frac  = mant_r[22:0];
    end

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      y_o = FP_QNAN;
    end else if (a_inf || b_inf) begin
      y_o = {sign, 8'hFF, 23'b0};
    end else if (a_zero || b_zero) begin
      y_o = {sign, 31'b0};
    end else if (exp_r >= 10'sd255) begin
      y_o = {sign, 8'hFF, 23'b0};
    end else if (exp_r <= 10'sd0) begin
      y_o = {sign, 31'b0};
    end else begin
      y_o = {sign, exp_r[7:0], frac};
    end
  end

endmodule

// File: rtl/sigmoid_backward.sv
// Sigmoid backward pass: out = g * s * (1 - s) in binary32, one transaction at a time.
// Sequence IDLE -> SUB (1 - s) -> MUL1 (s * oms) -> MUL2 (p * g) -> DONE (hold until taken).
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake, s = sigmoid output, g = upstream gradient
//   out_valid / out_ready: result handshake, out = delta, err = s illegal (outside [0,1] or NaN)
module sigmoid_backward
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] s,
  input  logic [31:0] g,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        err
);

  state_e      state_q, state_d;
  logic [31:0] s_q, s_d;
  logic [31:0] g_q, g_d;
  logic [31:0] oms_q, oms_d;
  logic [31:0] p_q, p_d;
  logic [31:0] out_q, out_d;
  logic        err_q, err_d;

  logic [31:0] mul_a, mul_b, mul_y;
  logic        s_bad;

  // 1 - s datapath signals.
  logic [7:0]   s_exp;
  logic [7:0]   align_sh;
  logic [151:0] s_wide;
  logic [26:0]  s_al, diff, norm;
  logic [4:0]   lz;
  logic [23:0]  oms_mant;
  logic         oms_rnd;
  logic [24:0]  oms_sum;
  logic [7:0]   oms_exp;
  logic [31:0]  oms_calc;

  // Negative nonzero, above 1.0, or NaN/Inf.
  assign s_bad = (s_q[31] && (s_q[30:0] != 31'b0)) ||
                 (!s_q[31] && (s_q > FP_ONE)) ||
                 (s_q[30:23] == 8'hFF);

  // Legal s lies in [2^-126, 1), so 1 - s is an exact-aligned subtract against 1.0.
  // Bit 26 of the 27-bit working value weighs 2^0; bits [2:0] are guard, round, sticky.
  always_comb begin
    s_exp    = s_q[30:23];
    align_sh = 8'd127 - s_exp;
    s_wide   = {1'b1, s_q[22:0], 128'b0} >> align_sh;
    s_al     = {s_wide[151:126], |s_wide[125:0]};
    diff     = 27'h400_0000 - s_al;

    lz = '0;
    for (int i = 0; i < 27; i++) begin
      if (diff[i]) lz = 5'(26 - i);
    end

    norm     = diff << lz;
    oms_mant = norm[26:3];
    oms_rnd  = norm[2] & ((|norm[1:0]) | norm[3]);
    oms_sum  = {1'b0, oms_mant} + {24'b0, oms_rnd};
    oms_exp  = 8'd127 - {3'b000, lz};

    if (s_exp == 8'd0) begin
      oms_calc = FP_ONE;
    end else if (s_exp >= 8'd127) begin
      // s = 1.0 gives +0; anything larger is illegal and its result is overridden.
      oms_calc = '0;
    end else if (oms_sum[24]) begin
      oms_calc = {1'b0, oms_exp + 8'd1, oms_sum[23:1]};
    end else begin
      oms_calc = {1'b0, oms_exp, oms_sum[22:0]};
    end
  end

  // Single multiplier shared by MUL1 and MUL2.
  assign mul_a = (state_q == StMul1) ? s_q   : p_q;
  assign mul_b = (state_q == StMul1) ? oms_q : g_q;

  fp32_mul u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .y_o (mul_y)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    g_d     = g_q;
    oms_d   = oms_q;
    p_d     = p_q;
    out_d   = out_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          s_d     = s;
          g_d     = g;
          state_d = StSub;
        end
      end
      StSub: begin
        oms_d   = oms_calc;
        state_d = StMul1;
      end
      StMul1: begin
        p_d     = mul_y;
        state_d = StMul2;
      end
      StMul2: begin
        out_d   = s_bad ? FP_QNAN : mul_y;
        err_d   = s_bad;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q   <= '0;
      g_q   <= '0;
      oms_q <= '0;
      p_q   <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      g_q   <= g_d;
      oms_q <= oms_d;
      p_q   <= p_d;
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out       = out_q;
  assign err       = err_q;

endmodule

// File: doc/sigmoid_backward.md
SIGMOID_BACKWARD -- requirements
Module: sigmoid_backward

Interface
REQ-001 The block SHALL have no parameters; all formats are fixed IEEE-754 binary32.
REQ-002 clk  input  1  single clock, all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  s and g are valid this cycle.
REQ-005 in_ready  output  1  block can accept a new operand pair.
REQ-006 s  input  32  forward sigmoid output, binary32.
REQ-007 g  input  32  upstream gradient, binary32.
REQ-008 out_valid  output  1  out and err are valid.
REQ-009 out_ready  input  1  downstream accepts out.
REQ-010 out  output  32  delta = g * s * (1 - s), binary32.
REQ-011 err  output  1  s was outside [0, 1] or NaN; qualified by out_valid.

Function
REQ-012 The FSM SHALL have the states IDLE, SUB, MUL1, MUL2 and DONE, with in_ready = 1 only in IDLE.
REQ-013 In IDLE with in_valid = 1, the block SHALL capture s and g into registers and go to SUB on the next edge.
REQ-014 SUB SHALL register oms = 1.0 - s and go to MUL1.
- Align the s mantissa right by (127 - exp).
- Keep guard and sticky bits, subtract, normalise, round to nearest even.
- s = 1.0 SHALL give +0.
REQ-015 MUL1 SHALL register p = s * oms using the shared multiplier and go to MUL2.
REQ-016 MUL2 SHALL register out = p * g using the same multiplier, set out_valid, and go to DONE.
REQ-017 The handshake latency SHALL be fixed:
- input accepted at edge k;
- out_valid high after edge k+3.
REQ-018 In DONE, out, err and out_valid SHALL hold stable until out_ready = 1; then, on that edge, the FSM returns to IDLE and out_valid clears.
REQ-019 The block SHALL hold one transaction at a time; sustained throughput is one result per 5 cycles when out_ready is held high.
REQ-020 Denormal inputs and intermediates SHALL be flushed to signed zero.
REQ-021 Underflowing results SHALL go to signed zero; overflowing results SHALL go to signed infinity.
REQ-022 Any of the following SHALL force out = 0x7FC00000 and err = 1; the FSM still runs the full 4-cycle sequence:
- s sign bit set with s nonzero;
- s > 1.0;
- s is NaN or Inf.
REQ-023 With s legal, these cases SHALL give out = 0x7FC00000 and err = 0:
- g is NaN;
- g = Inf with p = 0.
REQ-024 The result sign SHALL be the XOR of the operand signs, so -0 results are preserved.
REQ-025 in_valid while in_ready = 0 SHALL be ignored; it is the producer's job to hold it.

Reset
REQ-026 Asserting reset_n low SHALL immediately set:
- state = IDLE;
- in_ready = 1;
- out_valid = 0;
- err = 0;
- out = 0x00000000;
- all operand and intermediate registers = 0.
REQ-027 Reset during SUB, MUL1, MUL2 or DONE SHALL discard the in-flight transaction with no output produced.

Structure
REQ-028 A shared package fp32_pkg SHALL hold the following, so the forward sigmoid and this block share them:
- FP_ONE = 0x3F800000;
- FP_QNAN = 0x7FC00000;
- EXP_BIAS = 127;
- field widths (1/8/23);
- the FSM state enum.
REQ-029 One combinational sub-module, fp32_mul, SHALL implement a binary32 multiply with round-to-nearest-even, FTZ and NaN/Inf handling.
- It SHALL be instantiated once.
- It SHALL be shared by MUL1 and MUL2 through operand muxes.
REQ-030 The 1 - s subtract SHALL be implemented inline; it needs no general adder.

Verification
REQ-031 s = 0x3F000000 (0.5), g = 0x3F800000 (1.0) -> out = 0x3E800000 (0.25), err = 0, out_valid exactly 3 cycles after acceptance.
REQ-032 s = 0x3F400000 (0.75), g = 0x40000000 (2.0) -> out = 0x3EC00000 (0.375); s = 0x3F19999A (0.6), g = 1.0 -> out = 0x3E75C28F (0.24, RNE).
REQ-033 s = 0x3F800000 (1.0), g = 0xC0400000 (-3.0) -> out = 0x80000000; s = 0x00000000, g = 1.0 -> out = 0x00000000.
REQ-034 s = 0x3F800001 or s = 0xBF000000 -> out = 0x7FC00000, err = 1; g = 0x7F800000 with s = 1.0 -> out = 0x7FC00000, err = 0.
REQ-035 Backpressure: out_ready low for 3 cycles in DONE -> out, out_valid and in_ready = 0 held; release -> one-cycle handshake, then in_ready = 1.
REQ-036 Reset mid-MUL1 -> out_valid = 0 and in_ready = 1 immediately; no output after release; the next transaction (0.5, 1.0) completes with 0x3E800000.
